remote_cmd_arbiter: RTL and testbench
=====================================

// Module: remote_cmd_arbiter
// PURPOSE
//  Shares one RemoteComm link (16-bit cmd out, 8-bit resp in) among NUM_REQ requesters.
//  Arbitrates round-robin, launches the command, waits for cmd_snt and then the response
//  byte, and checks the response against ACK_BYTE. Retries on timeout and returns
//  done/resp/status to the winning requester. Sits between the test/host sequencers and
//  RemoteComm.
// PARAMETERS
//  NUM_REQ      4          number of requesters (2..8)
//  TIMEOUT_CYC  1_000_000  clk cycles allowed from snd_cmd to resp_rdy per attempt
//  MAX_RETRY    2          re-sends after a timeout before giving up
//  ACK_BYTE     8'hA5      response value meaning positive acknowledge
// PORTS
//  clk          in   1            clock
//  rst_n        in   1            reset, asynchronous, active-low
//  req          in   NUM_REQ      per-requester request level, held until done
//  req_cmd      in   NUM_REQ*16   flattened commands, requester i at [16*i+:16]
//  gnt          out  NUM_REQ      one-hot, high while requester i is being served
//  done         out  NUM_REQ      one-hot 1-cycle completion pulse
//  resp_out     out  8            response byte of last transaction (8'h00 on timeout fail)
//  ack_ok       out  1            valid with done: resp_out == ACK_BYTE
//  timeout_err  out  1            valid with done: all 1+MAX_RETRY attempts timed out
//  cmd          out  16           command to RemoteComm (latched copy)
//  snd_cmd      out  1            1-cycle launch pulse to RemoteComm
//  cmd_snt      in   1            level from RemoteComm, both bytes shifted out
//  resp_rdy     in   1            1-cycle pulse from RemoteComm, resp valid
//  resp         in   8            response byte from RemoteComm
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, rr pointer 0 (req[0] highest priority), retry_cnt 0.
//  - States: IDLE -> SEND -> WAIT_SNT -> WAIT_RESP -> DONE -> IDLE.
//  - IDLE: if |req, pick the first asserted index at or after the rr pointer (wrapping).
//    At the next edge: gnt[i]=1, cmd<=req_cmd[i], retry_cnt<=0, go to SEND.
//  - SEND: snd_cmd=1 for exactly this cycle. Clear the timeout counter. Go to WAIT_SNT.
//  - WAIT_SNT: wait for cmd_snt=1, then go to WAIT_RESP. cmd_snt is cleared by RemoteComm
//    on snd_cmd, so it is never sampled in the SEND cycle.
//  - resp_rdy seen in WAIT_SNT or WAIT_RESP: capture resp into resp_out,
//    ack_ok=(resp==ACK_BYTE), timeout_err=0, go to DONE. A non-ACK byte is reported,
//    not retried.
//  - Timeout: the counter runs in WAIT_SNT and WAIT_RESP, width $clog2(TIMEOUT_CYC+1).
//    When it reaches TIMEOUT_CYC:
//      - if retry_cnt<MAX_RETRY: retry_cnt++, go to SEND and resend the same latched cmd;
//      - else: resp_out=8'h00, ack_ok=0, timeout_err=1, go to DONE.
//  - DONE: done[i]=1 for one cycle. gnt drops at the next edge. rr pointer<=(i+1)%NUM_REQ.
//    Go to IDLE. ack_ok, timeout_err and resp_out hold until the next DONE.
//  - Latency, fault-free: req seen in cycle N -> gnt and SEND in N+1, snd_cmd in N+1.
//    done comes 1 cycle after resp_rdy.
//  - Gaps: at least 1 IDLE cycle between back-to-back transactions.
//  - Requesters and cmd: req dropped mid-transaction does not abort; done still pulses.
//    req_cmd changes after grant are ignored. cmd is stable from SEND through DONE.
//  - resp_rdy in IDLE, SEND or DONE is dropped with no output change.
//  - Simultaneous resp_rdy and timeout expiry in the same cycle: resp_rdy wins.
//  - Reset mid-transaction: immediate return to reset values. No done is issued.
// STRUCTURE
//  - remote_arb_pkg: arb_state_t enum {IDLE,SEND,WAIT_SNT,WAIT_RESP,DONE}, ACK_DEFAULT=8'hA5.
//  - Sub-module rr_arbiter #(N): req, ptr -> one-hot grant, purely combinational.
//  - This module owns the FSM, retry/timeout counters, cmd latch and result registers.
// TESTING  (bench: NUM_REQ=4, TIMEOUT_CYC=1000, MAX_RETRY=2, RemoteComm + UART-model DUT)
//  1. req[2]=1, cmd=16'h1234, DUT replies A5 -> snd_cmd once with cmd=1234;
//     done[2]; ack_ok=1, resp_out=A5.
//  2. req=4'b1011 held from reset -> service order 0,1,3,0 (round-robin wrap);
//     gnt always one-hot.
//  3. DUT silent for attempt 1, replies A5 on attempt 2 -> snd_cmd twice 1000 cycles apart;
//     done, ack_ok=1, timeout_err=0.
//  4. DUT always silent -> 3 snd_cmd pulses; done with timeout_err=1, resp_out=00.
//  5. DUT replies 8'h5A -> single attempt; done, ack_ok=0, resp_out=5A, no retry.
//  6. rst_n low during WAIT_RESP -> all outputs 0 next cycle, no done.
//     A stray resp_rdy in IDLE is ignored.

Source files
------------

// File: rtl/remote_arb_pkg.sv
// remote_arb_pkg: shared FSM state encoding and default acknowledge byte for remote_cmd_arbiter
package remote_arb_pkg;
    typedef enum logic [2:0] {IDLE, SEND, WAIT_SNT, WAIT_RESP, DONE} arb_state_t;
    localparam logic [7:0] ACK_DEFAULT = 8'hA5;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or after i_ptr (wrapping)
//   i_req  [N-1:0]  request levels
//   i_ptr  [IW-1:0] highest-priority index
//   o_gnt  [N-1:0]  one-hot winner (0 when no request)
//   o_idx  [IW-1:0] binary index of the winner
module rr_arbiter #(
    parameter int N = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_gnt,
    output logic [IW-1:0] o_idx
);
    // Scan from the farthest offset down so the closest request to i_ptr overwrites last.
    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (i_req[(int'(i_ptr) + k) % N]) begin
                o_gnt = N'(1) << ((int'(i_ptr) + k) % N);
                o_idx = IW'((int'(i_ptr) + k) % N);
            end
        end
    end
endmodule

// File: rtl/remote_cmd_arbiter.sv
// remote_cmd_arbiter: round-robin sharing of one RemoteComm link with timeout retry and ACK check
//   clk, rst_n         clock, asynchronous active-low reset
//   i_req/i_req_cmd    per-requester request level and flattened 16-bit commands
//   o_gnt/o_done       one-hot grant while served, one-hot 1-cycle completion pulse
//   o_resp_out/o_ack_ok/o_timeout_err  result of last transaction, valid with o_done
//   o_cmd/o_snd_cmd    latched command and launch pulse to RemoteComm
//   i_cmd_snt/i_resp_rdy/i_resp        status and response from RemoteComm
module remote_cmd_arbiter
    import remote_arb_pkg::*;
#(
    parameter int          NUM_REQ     = 4,
    parameter int          TIMEOUT_CYC = 1_000_000,
    parameter int          MAX_RETRY   = 2,
    parameter logic [7:0]  ACK_BYTE    = ACK_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    i_req,
    input  logic [NUM_REQ*16-1:0] i_req_cmd,
    output logic [NUM_REQ-1:0]    o_gnt,
    output logic [NUM_REQ-1:0]    o_done,
    output logic [7:0]            o_resp_out,
    output logic                  o_ack_ok,
    output logic                  o_timeout_err,
    output logic [15:0]           o_cmd,
    output logic                  o_snd_cmd,
    input  logic                  i_cmd_snt,
    input  logic                  i_resp_rdy,
    input  logic [7:0]            i_resp
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    arb_state_t          r_state, w_next;
    logic [IW-1:0]       r_ptr, r_idx, w_idx;
    logic [NUM_REQ-1:0]  r_gnt, w_gnt;
    logic [15:0]         r_cmd;
    logic [TW-1:0]       r_tmo;
    logic [RW-1:0]       r_retry;
    logic [7:0]          r_resp;
    logic                r_ack, r_terr;
    logic                w_waiting, w_load, w_resp_hit, w_tmo_hit, w_retry, w_fail;

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .i_req (i_req),
        .i_ptr (r_ptr),
        .o_gnt (w_gnt),
        .o_idx (w_idx)
    );

    assign w_waiting  = (r_state == WAIT_SNT) || (r_state == WAIT_RESP);
    assign w_load     = (r_state == IDLE) && |i_req;
    assign w_resp_hit = w_waiting && i_resp_rdy;
    // A response arriving in the expiry cycle takes precedence over the timeout.
    assign w_tmo_hit  = w_waiting && !i_resp_rdy && (r_tmo == TW'(TIMEOUT_CYC));
    assign w_retry    = w_tmo_hit && (r_retry < RW'(MAX_RETRY));
    assign w_fail     = w_tmo_hit && !w_retry;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:      w_next = |i_req ? SEND : IDLE;
            SEND:      w_next = WAIT_SNT;
            WAIT_SNT:  w_next = (w_resp_hit || w_fail) ? DONE : w_retry ? SEND : i_cmd_snt ? WAIT_RESP : WAIT_SNT;
            WAIT_RESP: w_next = (w_resp_hit || w_fail) ? DONE : w_retry ? SEND : WAIT_RESP;
            DONE:      w_next = IDLE;
            default:   w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr   <= '0;
            r_idx   <= '0;
            r_gnt   <= '0;
            r_cmd   <= '0;
            r_tmo   <= '0;
            r_retry <= '0;
            r_resp  <= '0;
            r_ack   <= 1'b0;
            r_terr  <= 1'b0;
        end else begin
            if (w_load) begin
                r_gnt   <= w_gnt;
                r_idx   <= w_idx;
                r_cmd   <= i_req_cmd[{w_idx, 4'b0000} +: 16];
                r_retry <= '0;
            end
            if (r_state == SEND)  r_tmo <= '0;
            else if (w_waiting)   r_tmo <= r_tmo + 1'b1;
            if (w_retry)          r_retry <= r_retry + 1'b1;
            if (w_resp_hit) begin
                r_resp <= i_resp;
                r_ack  <= (i_resp == ACK_BYTE);
                r_terr <= 1'b0;
            end
            if (w_fail) begin
                r_resp <= 8'h00;
                r_ack  <= 1'b0;
                r_terr <= 1'b1;
            end
            if (r_state == DONE) begin
                r_gnt <= '0;
                r_ptr <= (r_idx == IW'(NUM_REQ - 1)) ? '0 : r_idx + 1'b1;
            end
        end
    end

    assign o_gnt         = r_gnt;
    assign o_done        = (r_state == DONE) ? r_gnt : '0;
    assign o_snd_cmd     = (r_state == SEND);
    assign o_cmd         = r_cmd;
    assign o_resp_out    = r_resp;
    assign o_ack_ok      = r_ack;
    assign o_timeout_err = r_terr;
endmodule

// File: tb/tb_remote_cmd_arbiter.sv
// tb_remote_cmd_arbiter: directed bench with a behavioural RemoteComm responder
module tb_remote_cmd_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [63:0] req_cmd;
    logic [3:0]  gnt, done;
    logic [7:0]  resp_out, resp;
    logic        ack_ok, timeout_err, snd_cmd, cmd_snt, resp_rdy;
    logic [15:0] cmd;

    int n_tests = 0, n_fail = 0;
    int cyc = 0, snd_cnt = 0, n_done = 0, gnt_bad = 0;
    int snd_t[$];
    logic [3:0]  d_vec;
    logic [7:0]  d_resp;
    logic        d_ack, d_terr;
    logic [15:0] d_cmd;
    int rc_att, rc_silent;
    logic [7:0] rc_byte;

    always #5 clk = ~clk;

    remote_cmd_arbiter #(.NUM_REQ(4), .TIMEOUT_CYC(1000), .MAX_RETRY(2)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_req         (req),
        .i_req_cmd     (req_cmd),
        .o_gnt         (gnt),
        .o_done        (done),
        .o_resp_out    (resp_out),
        .o_ack_ok      (ack_ok),
        .o_timeout_err (timeout_err),
        .o_cmd         (cmd),
        .o_snd_cmd     (snd_cmd),
        .i_cmd_snt     (cmd_snt),
        .i_resp_rdy    (resp_rdy),
        .i_resp        (resp)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_gnt"}, 32'(gnt), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_snd"}, 32'(snd_cmd), 0);
        check({tag, "_cmd"}, 32'(cmd), 0);
        check({tag, "_resp"}, 32'(resp_out), 0);
        check({tag, "_ack"}, 32'(ack_ok), 0);
        check({tag, "_terr"}, 32'(timeout_err), 0);
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n0 = n_done;
        int k = 0;
        while (n_done == n0 && k < budget) begin
            tick();
            k++;
        end
        check({tag, "_done_seen"}, 32'(n_done != n0), 1);
    endtask

    // RemoteComm model: cmd_snt 3 cycles after launch, response 2 cycles later unless
    // this attempt is one of the first rc_silent attempts.
    task automatic responder();
        forever begin
            @(negedge clk);
            if (snd_cmd) begin
                rc_att++;
                cmd_snt = 1'b0;
                repeat (3) @(negedge clk);
                cmd_snt = 1'b1;
                if (rc_att > rc_silent) begin
                    repeat (2) @(negedge clk);
                    resp = rc_byte;
                    resp_rdy = 1'b1;
                    @(negedge clk);
                    resp_rdy = 1'b0;
                end
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (snd_cmd) begin
                snd_cnt++;
                snd_t.push_back(cyc);
            end
            if ($countones(gnt) > 1) gnt_bad++;
            if (|done) begin
                n_done++;
                d_vec  = done;
                d_resp = resp_out;
                d_ack  = ack_ok;
                d_terr = timeout_err;
                d_cmd  = cmd;
            end
        end
    end

    initial begin
        int s0, q0, n0;
        rst_n = 1'b0; req = '0; req_cmd = '0; cmd_snt = 1'b0; resp_rdy = 1'b0; resp = '0;
        rc_att = 0; rc_silent = 0; rc_byte = 8'hA5;
        fork responder(); join_none
        repeat (3) tick();
        check_zero("rst");
        rst_n = 1'b1;
        tick();

        // 1: single request, ACK reply, one-cycle grant latency
        req_cmd = 64'h0000_1234_1111_2222;
        req = 4'b0100;
        s0 = snd_cnt;
        tick();
        check("t1_snd", 32'(snd_cmd), 1);
        check("t1_gnt", 32'(gnt), 32'h4);
        check("t1_cmd", 32'(cmd), 32'h1234);
        req_cmd = 64'hFFFF_FFFF_FFFF_FFFF;
        wait_done("t1", 200);
        req = '0;
        check("t1_vec", 32'(d_vec), 32'h4);
        check("t1_ack", 32'(d_ack), 1);
        check("t1_resp", 32'(d_resp), 32'hA5);
        check("t1_terr", 32'(d_terr), 0);
        check("t1_dcmd", 32'(d_cmd), 32'h1234);
        check("t1_nsnd", 32'(snd_cnt - s0), 1);

        // 2: req=1011 held from reset, order 0,1,3,0
        rst_n = 1'b0;
        req_cmd = 64'h4444_3333_2222_1111;
        req = 4'b1011;
        tick();
        rst_n = 1'b1;
        gnt_bad = 0;
        begin
            logic [3:0]  ev [4] = '{4'b0001, 4'b0010, 4'b1000, 4'b0001};
            logic [15:0] ec [4] = '{16'h1111, 16'h2222, 16'h4444, 16'h1111};
            for (int i = 0; i < 4; i++) begin
                wait_done($sformatf("t2_%0d", i), 200);
                check($sformatf("t2_vec%0d", i), 32'(d_vec), 32'(ev[i]));
                check($sformatf("t2_cmd%0d", i), 32'(d_cmd), 32'(ec[i]));
            end
        end
        req = '0;
        check("t2_onehot", 32'(gnt_bad), 0);

        // 3: first attempt silent, second answered
        rc_att = 0; rc_silent = 1; rc_byte = 8'hA5;
        s0 = snd_cnt; q0 = snd_t.size();
        req = 4'b0001;
        wait_done("t3", 3000);
        req = '0;
        check("t3_nsnd", 32'(snd_cnt - s0), 2);
        if (snd_t.size() >= q0 + 2)
            check("t3_gap", 32'((snd_t[q0+1] - snd_t[q0]) >= 1000 && (snd_t[q0+1] - snd_t[q0]) <= 1002), 1);
        else
            check("t3_gap_present", 32'(snd_t.size() - q0), 2);
        check("t3_ack", 32'(d_ack), 1);
        check("t3_terr", 32'(d_terr), 0);
        check("t3_resp", 32'(d_resp), 32'hA5);

        // 4: always silent -> three attempts then timeout error
        rc_att = 0; rc_silent = 99;
        s0 = snd_cnt;
        req = 4'b0010;
        wait_done("t4", 5000);
        req = '0;
        check("t4_nsnd", 32'(snd_cnt - s0), 3);
        check("t4_vec", 32'(d_vec), 32'h2);
        check("t4_terr", 32'(d_terr), 1);
        check("t4_resp", 32'(d_resp), 0);
        check("t4_ack", 32'(d_ack), 0);

        // 5: NAK byte reported without retry
        rc_att = 0; rc_silent = 0; rc_byte = 8'h5A;
        s0 = snd_cnt;
        req = 4'b1000;
        wait_done("t5", 200);
        req = '0;
        check("t5_nsnd", 32'(snd_cnt - s0), 1);
        check("t5_ack", 32'(d_ack), 0);
        check("t5_resp", 32'(d_resp), 32'h5A);
        check("t5_terr", 32'(d_terr), 0);

        // 6: reset during WAIT_RESP, then a stray resp_rdy in IDLE
        rc_att = 0; rc_silent = 99;
        s0 = snd_cnt;
        req = 4'b0100;
        begin
            int k = 0;
            while (snd_cnt == s0 && k < 50) begin
                tick();
                k++;
            end
            check("t6_launch", 32'(snd_cnt != s0), 1);
        end
        repeat (10) tick();
        n0 = n_done;
        #2 rst_n = 1'b0;
        #1 check_zero("t6_rst");
        req = '0;
        tick();
        rst_n = 1'b1;
        repeat (2) tick();
        s0 = snd_cnt;
        resp = 8'h77;
        resp_rdy = 1'b1;
        tick();
        resp_rdy = 1'b0;
        repeat (3) tick();
        check("t6_stray_resp", 32'(resp_out), 0);
        check("t6_no_done", 32'(n_done - n0), 0);
        check("t6_no_snd", 32'(snd_cnt - s0), 0);
        check("t6_gnt", 32'(gnt), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
